dp_frame_sched: RTL and testbench

//  Frame/line scheduler for the DP main-link stuffer. Times lines and frames in dpclk

---
 rtl/dp_frame_sched_pkg.sv | 22 ++
 rtl/dp_line_timer.sv | 49 ++++
 rtl/dp_frame_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_dp_frame_sched.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dp_frame_sched_pkg.sv
// Shared types and helpers for the DP frame/line scheduler.
package dp_frame_sched_pkg;

    typedef enum logic [1:0] {
        SCH_IDLE = 2'd0,
        SCH_RUN  = 2'd1,
        SCH_STOP = 2'd2
    } sch_state_t;

    localparam int unsigned DEF_MINLINE = 16;

    // Line that carries the DMA kick: vdata - lead, folded back into the frame on borrow.
    function automatic logic [15:0] dma_line(input logic [15:0] vdata,
                                             input logic [3:0]  lead,
                                             input logic [15:0] vtot);
        logic [16:0] diff;
        diff = {1'b0, vdata} - {13'd0, lead};
        if (diff[16]) dma_line = diff[15:0] + vtot;
        else          dma_line = diff[15:0];
    endfunction

endpackage

// File: rtl/dp_line_timer.sv
// Line period timer: 16-bit down-counter plus 8-bit fractional accumulator.
module dp_line_timer
    import dp_frame_sched_pkg::*;
#(
    parameter int unsigned MINLINE = DEF_MINLINE
) (
    input  logic        dpclk,
    input  logic        reset,
    input  logic        run,
    input  logic [23:0] linediv,
    output logic        lineevt
);

    logic [15:0] hcnt_q, hcnt_d;
    logic [7:0]  frac_q, frac_d;
    logic [15:0] ipart;
    logic [8:0]  fsum;
    logic [16:0] period;

    always_comb begin
        ipart   = (linediv[23:8] < 16'(MINLINE)) ? 16'(MINLINE) : linediv[23:8];
        fsum    = {1'b0, frac_q} + {1'b0, linediv[7:0]};
        // The fractional carry stretches this line by one cycle so the average stays exact.
        period  = {1'b0, ipart} + {16'd0, fsum[8]};
        lineevt = run && (hcnt_q == '0);
        hcnt_d  = hcnt_q;
        frac_d  = frac_q;
        if (!run) begin
            hcnt_d = '0;
            frac_d = '0;
        end else if (lineevt) begin
            hcnt_d = 16'(period - 17'd1);
            frac_d = fsum[7:0];
        end else begin
            hcnt_d = hcnt_q - 16'd1;
        end
    end

    always_ff @(posedge dpclk) begin
        if (reset) begin
            hcnt_q <= '0;
            frac_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            frac_q <= frac_d;
        end
    end

endmodule

// File: rtl/dp_frame_sched.sv
// DP main-link frame/line scheduler: line/frame pulses, DMA kick, underrun recovery.
// Optional DP_SCHED_STATS_EN adds frames/urcount statistics outputs.
module dp_frame_sched
    import dp_frame_sched_pkg::*;
#(
    parameter int unsigned MINLINE      = DEF_MINLINE,
    parameter int unsigned UNDERRUN_CYC = 4,
    parameter int unsigned FIFORST_CYC  = 16
) (
    input  logic        dpclk,
    input  logic        reset,
    input  logic        enable,
    input  logic [23:0] linediv,
    input  logic [15:0] vtot,
    input  logic [15:0] vdata,
    input  logic [15:0] vact,
    input  logic [3:0]  dmalead,
    input  logic        fifoempty,
    input  logic        clr_status,
    output logic        dphstart,
    output logic        dpvstart,
    output logic        dmastart,
    output logic        fiforeset,
    output logic [15:0] line,
    output logic        active,
    output logic        underrun
`ifdef DP_SCHED_STATS_EN
    ,
    output logic [15:0] frames,
    output logic [7:0]  urcount
`endif
);

    localparam int unsigned URW = $clog2(UNDERRUN_CYC + 1);
    localparam int unsigned FRW = $clog2(FIFORST_CYC + 1);

    sch_state_t state_q, state_d;
    logic [23:0] ldiv_q, ldiv_d;
    logic [15:0] vtot_q, vtot_d, vdata_q, vdata_d, vact_q, vact_d;
    logic [3:0]  lead_q, lead_d;
    logic [15:0] vcnt_q, vcnt_d, line_q, line_d;
    logic        active_q, active_d, dphstart_q, dphstart_d;
    logic        dpvstart_q, dpvstart_d, dmastart_q, dmastart_d;
    logic [FRW-1:0] frst_q, frst_d;
    logic [URW-1:0] ecnt_q, ecnt_d;
    logic        underrun_q, underrun_d, armed_q, armed_d, pend_q, pend_d;
    logic        lineevt, load, urset, rec;
    logic [15:0] dma_ln, rec_line;
    logic        in_act;

    dp_line_timer #(
        .MINLINE(MINLINE)
    ) u_line_timer (
        .dpclk  (dpclk),
        .reset  (reset),
        .run    (state_q != SCH_IDLE),
        .linediv(ldiv_q),
        .lineevt(lineevt)
    );

    // vcnt_q holds the index of the line that the next line event starts.
    assign dma_ln   = dma_line(vdata_q, lead_q, vtot_q);
    assign rec_line = vdata_q + vact_q;
    assign in_act   = (vcnt_q >= vdata_q) && ({1'b0, vcnt_q} < ({1'b0, vdata_q} + {1'b0, vact_q}));

    always_comb begin
        state_d    = state_q;
        ldiv_d     = ldiv_q;
        vtot_d     = vtot_q;
        vdata_d    = vdata_q;
        vact_d     = vact_q;
        lead_d     = lead_q;
        vcnt_d     = vcnt_q;
        line_d     = line_q;
        active_d   = active_q;
        dphstart_d = 1'b0;
        dpvstart_d = 1'b0;
        dmastart_d = 1'b0;
        frst_d     = frst_q;
        ecnt_d     = ecnt_q;
        underrun_d = underrun_q;
        armed_d    = armed_q;
        pend_d     = pend_q;
        load       = 1'b0;
        urset      = 1'b0;
        rec        = 1'b0;

        case (state_q)
            SCH_IDLE: if (enable) begin
                state_d = SCH_RUN;
                load    = 1'b1;
                vcnt_d  = '0;
            end
            SCH_RUN:  if (!enable) state_d = SCH_STOP;
            SCH_STOP: begin
                if (enable)                         state_d = SCH_RUN;
                else if (lineevt && vcnt_q == '0)   state_d = SCH_IDLE;
            end
            default:  state_d = SCH_IDLE;
        endcase

        if (frst_q != '0) frst_d = frst_q - FRW'(1);
        if (pend_q && frst_q == '0) begin
            dmastart_d = 1'b1;
            pend_d     = 1'b0;
        end

        if (lineevt && state_d != SCH_IDLE) begin
            dphstart_d = 1'b1;
            line_d     = vcnt_q;
            active_d   = in_act;
            dpvstart_d = (vcnt_q == vdata_q);
            rec        = armed_q && (vcnt_q == rec_line);
            if (rec) begin
                frst_d  = FRW'(FIFORST_CYC);
                armed_d = 1'b0;
            end
            // A kick that would land while the FIFO is being flushed waits for the flush to end.
            if (vcnt_q == dma_ln) begin
                if (frst_q != '0 || rec) pend_d = 1'b1;
                else                     dmastart_d = 1'b1;
            end
            if (vcnt_q == vtot_q - 16'd1) begin
                vcnt_d = '0;
                load   = 1'b1;
            end else begin
                vcnt_d = vcnt_q + 16'd1;
            end
        end

        if (state_d == SCH_IDLE) begin
            active_d   = 1'b0;
            pend_d     = 1'b0;
            dmastart_d = 1'b0;
        end

        if (active_q && !lineevt && fifoempty) begin
            if (ecnt_q == URW'(UNDERRUN_CYC - 1)) urset = 1'b1;
            if (ecnt_q != URW'(UNDERRUN_CYC))     ecnt_d = ecnt_q + URW'(1);
        end else begin
            ecnt_d = '0;
        end
        if (clr_status) underrun_d = 1'b0;
        if (urset) begin
            underrun_d = 1'b1;
            armed_d    = 1'b1;
        end

        if (load) begin
            ldiv_d  = linediv;
            vtot_d  = vtot;
            vdata_d = vdata;
            vact_d  = vact;
            lead_d  = dmalead;
        end
    end

    always_ff @(posedge dpclk) begin
        if (reset) begin
            state_q    <= SCH_IDLE;
            ldiv_q     <= '0;
            vtot_q     <= '0;
            vdata_q    <= '0;
            vact_q     <= '0;
            lead_q     <= '0;
            vcnt_q     <= '0;
            line_q     <= '0;
            active_q   <= 1'b0;
            dphstart_q <= 1'b0;
            dpvstart_q <= 1'b0;
            dmastart_q <= 1'b0;
            frst_q     <= '0;
            ecnt_q     <= '0;
            underrun_q <= 1'b0;
            armed_q    <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ldiv_q     <= ldiv_d;
            vtot_q     <= vtot_d;
            vdata_q    <= vdata_d;
            vact_q     <= vact_d;
            lead_q     <= lead_d;
            vcnt_q     <= vcnt_d;
            line_q     <= line_d;
            active_q   <= active_d;
            dphstart_q <= dphstart_d;
            dpvstart_q <= dpvstart_d;
            dmastart_q <= dmastart_d;
            frst_q     <= frst_d;
            ecnt_q     <= ecnt_d;
            underrun_q <= underrun_d;
            armed_q    <= armed_d;
            pend_q     <= pend_d;
        end
    end

    assign dphstart  = dphstart_q;
    assign dpvstart  = dpvstart_q;
    assign dmastart  = dmastart_q;
    assign fiforeset = (frst_q != '0);
    assign line      = line_q;
    assign active    = active_q;
    assign underrun  = underrun_q;

`ifdef DP_SCHED_STATS_EN
    logic [15:0] frames_q, frames_d;
    logic [7:0]  urcount_q, urcount_d;

    always_comb begin
        frames_d  = frames_q;
        urcount_d = urcount_q;
        if (dpvstart_d) frames_d = frames_q + 16'd1;
        if (clr_status) urcount_d = '0;
        if (urset && urcount_d != 8'hFF) urcount_d = urcount_d + 8'd1;
    end

    always_ff @(posedge dpclk) begin
        if (reset) begin
            frames_q  <= '0;
            urcount_q <= '0;
        end else begin
            frames_q  <= frames_d;
            urcount_q <= urcount_d;
        end
    end

    assign frames  = frames_q;
    assign urcount = urcount_q;
`endif

endmodule

// File: tb/tb_dp_frame_sched.sv
// Directed self-checking bench for dp_frame_sched (stats checks when DP_SCHED_STATS_EN).
module tb_dp_frame_sched;

    logic        dpclk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [23:0] linediv = '0;
    logic [15:0] vtot = '0, vdata = '0, vact = '0;
    logic [3:0]  dmalead = '0;
    logic        fifoempty = 1'b0, clr_status = 1'b0;
    logic        dphstart, dpvstart, dmastart, fiforeset, active, underrun;
    logic [15:0] line;
`ifdef DP_SCHED_STATS_EN
    logic [15:0] frames;
    logic [7:0]  urcount;
`endif

    int          nchecks = 0, nerrors = 0;
    int unsigned cyc = 0, t_hs = 0, ivl = 0, dma_cnt = 0, t0 = 0, n = 0;
    bit          got;

    always #5 dpclk = ~dpclk;
    always @(posedge dpclk) cyc <= cyc + 1;
    always @(negedge dpclk) if (dmastart) dma_cnt <= dma_cnt + 1;

    dp_frame_sched #(
        .MINLINE(16),
        .UNDERRUN_CYC(4),
        .FIFORST_CYC(16)
    ) dut (
        .dpclk     (dpclk),
        .reset     (reset),
        .enable    (enable),
        .linediv   (linediv),
        .vtot      (vtot),
        .vdata     (vdata),
        .vact      (vact),
        .dmalead   (dmalead),
        .fifoempty (fifoempty),
        .clr_status(clr_status),
        .dphstart  (dphstart),
        .dpvstart  (dpvstart),
        .dmastart  (dmastart),
        .fiforeset (fiforeset),
        .line      (line),
        .active    (active),
        .underrun  (underrun)
`ifdef DP_SCHED_STATS_EN
        ,
        .frames    (frames),
        .urcount   (urcount)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        nchecks++;
        if (got_v !== exp_v) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge dpclk);
    endtask

    // Steps until a dphstart is seen or the limit expires; ivl is the gap to the previous one.
    task automatic wait_hs(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge dpclk);
            if (dphstart) begin
                seen = 1'b1;
                ivl  = cyc - t_hs;
                t_hs = cyc;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        step(3);
        chk("rst_pulses", {dphstart, dpvstart, dmastart, fiforeset}, 4'h0);
        chk("rst_line", line, 16'd0);
        chk("rst_flags", {active, underrun}, 2'b00);
        reset = 1'b0;
        step(2);

        // 100.5-cycle lines, 4-line frame, active lines 1..2, DMA kick on line 0
        linediv = 24'h006480; vtot = 16'd4; vdata = 16'd1; vact = 16'd2; dmalead = 4'd1;
        t0 = cyc;
        enable = 1'b1;
        wait_hs(10, got);  chk("a_hs0_seen", got, 1);
        chk("a_latency", t_hs - t0, 2);
        chk("a_l0_line", line, 0);
        chk("a_l0_dma", dmastart, 1);
        chk("a_l0_vs", dpvstart, 0);
        chk("a_l0_act", active, 0);
        wait_hs(120, got); chk("a_l1_seen", got, 1);
        chk("a_l1_ivl", ivl, 100);
        chk("a_l1_line", line, 1);
        chk("a_l1_vs", dpvstart, 1);
        chk("a_l1_act", active, 1);
        chk("a_l1_dma", dmastart, 0);
        fifoempty = 1'b1; step(3); fifoempty = 1'b0; step(2);
        chk("a_empty3_no_ur", underrun, 0);
        wait_hs(120, got); chk("a_l2_ivl", ivl, 101);
        chk("a_l2_line", line, 2);
        chk("a_l2_act", active, 1);
        wait_hs(120, got); chk("a_l3_ivl", ivl, 100);
        chk("a_l3_line", line, 3);
        chk("a_l3_act", active, 0);
        chk("a_l3_nofr", fiforeset, 0);
        wait_hs(120, got); chk("a_f1l0_ivl", ivl, 101);
        chk("a_f1l0_line", line, 0);
        chk("a_f1l0_dma", dmastart, 1);
        wait_hs(120, got); chk("a_f1l1_ivl", ivl, 100);
        fifoempty = 1'b1; step(4); fifoempty = 1'b0; step(1);
        chk("a_empty4_ur", underrun, 1);
`ifdef DP_SCHED_STATS_EN
        chk("a_urcount1", urcount, 1);
`endif
        wait_hs(120, got); chk("a_f1l2_line", line, 2);
        chk("a_f1l2_nofr", fiforeset, 0);
        wait_hs(120, got); chk("a_f1l3_line", line, 3);
        chk("a_f1l3_fr", fiforeset, 1);
        n = 0;
        while (fiforeset && n < 40) begin
            n++;
            step(1);
        end
        chk("a_fr_len", n, 16);
        chk("a_ur_sticky", underrun, 1);
        clr_status = 1'b1; step(1); clr_status = 1'b0;
        chk("a_ur_clr", underrun, 0);
        wait_hs(120, got); chk("a_f2l0_line", line, 0);
        chk("a_f2l0_dma", dmastart, 1);
        wait_hs(120, got); chk("a_f2l1_line", line, 1);
        enable = 1'b0;
        wait_hs(120, got); chk("a_stop_l2", line, 2);
        chk("a_stop_l2_ivl", ivl, 101);
        wait_hs(120, got); chk("a_stop_l3", line, 3);
        chk("a_stop_l3_seen", got, 1);
        wait_hs(250, got); chk("a_idle_quiet", got, 0);
        chk("a_dma_cnt", dma_cnt, 3);
        chk("a_idle_act", active, 0);
`ifdef DP_SCHED_STATS_EN
        chk("a_frames3", frames, 3);
        chk("a_urcount0", urcount, 0);
`endif

        // Clamped 16-cycle lines, active 0..2, vstart and DMA kick on line 0
        linediv = 24'h000500; vtot = 16'd4; vdata = 16'd0; vact = 16'd3; dmalead = 4'd0;
        enable = 1'b1;
        wait_hs(10, got);  chk("b_l0_seen", got, 1);
        chk("b_l0_line", line, 0);
        chk("b_l0_vs_dma", {dpvstart, dmastart}, 2'b11);
        chk("b_l0_act", active, 1);
        wait_hs(20, got);  chk("b_l1_ivl", ivl, 16);
        chk("b_l1_line", line, 1);
        fifoempty = 1'b1; step(4); fifoempty = 1'b0;
        chk("b_ur", underrun, 1);
        wait_hs(20, got);  chk("b_l2_ivl", ivl, 16);
        wait_hs(20, got);  chk("b_l3_ivl", ivl, 16);
        chk("b_l3_fr_act", {fiforeset, active}, 2'b10);
        wait_hs(20, got);  chk("b_f1l0_ivl", ivl, 16);
        chk("b_f1l0_line", line, 0);
        chk("b_f1l0_fr", fiforeset, 0);
        chk("b_f1l0_vs_dma", {dpvstart, dmastart}, 2'b10);
        step(1);
        chk("b_dma_deferred", dmastart, 1);
        wait_hs(20, got);  chk("b_f1l1_line", line, 1);
        fifoempty = 1'b1; step(4); fifoempty = 1'b0;
        wait_hs(20, got);  chk("b_f1l2_line", line, 2);
        wait_hs(20, got);  chk("b_f1l3_fr", fiforeset, 1);
`ifdef DP_SCHED_STATS_EN
        chk("b_frames5", frames, 5);
        chk("b_urcount2", urcount, 2);
`endif
        step(2);
        clr_status = 1'b1; step(1); clr_status = 1'b0;
        chk("b_clr_ur", underrun, 0);
        chk("b_clr_keeps_fr", fiforeset, 1);
`ifdef DP_SCHED_STATS_EN
        chk("b_clr_urcount", urcount, 0);
`endif
        enable = 1'b0;
        reset = 1'b1;
        step(1);
        chk("c_rst_pulses", {dphstart, dpvstart, dmastart, fiforeset}, 4'h0);
        chk("c_rst_line", line, 16'd0);
        chk("c_rst_flags", {active, underrun}, 2'b00);
`ifdef DP_SCHED_STATS_EN
        chk("c_rst_stats", {frames, urcount}, 24'h0);
`endif
        reset = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
